// File: rtl/led_sequencer.sv
// Green LED pattern sequencer: prescaled tick drives count, rotate,
// bounce or PWM-breathe patterns onto the LED bank.
module led_sequencer #(
  parameter int DIV = 2400000,
  parameter int LW  = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [1:0]    mode,
  input  logic [1:0]    speed,
  input  logic          pause,
  input  logic          step,
  output logic [LW-1:0] led,
  output logic          tick
);

  localparam int PW = $clog2(DIV);

  localparam logic [1:0] M_COUNT   = 2'd0;
  localparam logic [1:0] M_SHIFT   = 2'd1;
  localparam logic [1:0] M_BOUNCE  = 2'd2;
  localparam logic [1:0] M_BREATHE = 2'd3;

  logic [PW-1:0] pcnt;
  logic [3:0]    pwm;
  logic [1:0]    mode_q;
  logic [LW-1:0] pat;
  logic [3:0]    duty;
  logic          dir;

  logic [31:0]   lim_m1;
  logic          wrap;
  logic          adv;

  logic [1:0]    mode_n;
  logic [LW-1:0] pat_n;
  logic [3:0]    duty_n;
  logic          dir_n;

  // >= rather than == so a mid-count speed-up fires at once
  assign lim_m1 = (32'(DIV) >> speed) - 32'd1;
  assign wrap   = 32'(pcnt) >= lim_m1;
  assign adv    = pause ? step : wrap;

  always_comb begin
    mode_n = mode_q;
    pat_n  = pat;
    duty_n = duty;
    dir_n  = dir;
    if (adv) begin
      if (mode != mode_q) begin
        mode_n = mode;
        dir_n  = 1'b1;
        duty_n = '0;
        pat_n  = (mode == M_COUNT) ? '0 : LW'(1);
      end else begin
        unique case (mode_q)
          M_COUNT: pat_n = pat + LW'(1);
          M_SHIFT: pat_n = {pat[LW-2:0], pat[LW-1]};
          M_BOUNCE: begin
            if (dir) begin
              pat_n = pat << 1;
              if (pat[LW-2]) dir_n = 1'b0;
            end else begin
              pat_n = pat >> 1;
              if (pat[1]) dir_n = 1'b1;
            end
          end
          M_BREATHE: begin
            if (dir) begin
              duty_n = duty + 4'd1;
              if (duty == 4'd14) dir_n = 1'b0;
            end else begin
              duty_n = duty - 4'd1;
              if (duty == 4'd1) dir_n = 1'b1;
            end
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pcnt   <= '0;
      pwm    <= '0;
      mode_q <= M_COUNT;
      pat    <= '0;
      duty   <= '0;
      dir    <= 1'b1;
      led    <= '0;
      tick   <= 1'b0;
    end else begin
      if (!pause) pcnt <= adv ? '0 : pcnt + PW'(1);
      pwm    <= pwm + 4'd1;
      mode_q <= mode_n;
      pat    <= pat_n;
      duty   <= duty_n;
      dir    <= dir_n;
      tick   <= adv;
      led    <= (mode_n == M_BREATHE) ? {LW{pwm < duty_n}} : pat_n;
    end
  end

endmodule

// File: tb/tb_led_sequencer.sv
// Self-checking bench for led_sequencer: directed steps plus random
// stimulus against a phase-based behavioural model.
module tb_led_sequencer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [1:0] mode = 2'd0;
  logic [1:0] speed = 2'd0;
  logic       pause = 1'b0;
  logic       step = 1'b0;
  logic [7:0] led;
  logic       tick;

  int errors = 0;
  int checks = 0;

  led_sequencer #(.DIV(16), .LW(8)) dut (
    .clk(clk), .rst_n(rst_n), .mode(mode), .speed(speed),
    .pause(pause), .step(step), .led(led), .tick(tick)
  );

  always #5 clk = ~clk;

  // model: counters since last advance and per-pattern phase indices
  int m_pc, m_modeq, m_cnt, m_rot, m_bq, m_bph, m_pwm;
  logic [7:0] exp_led;
  logic       exp_tick;

  function automatic int bph_duty(input int ph);
    return (ph <= 15) ? ph : 30 - ph;
  endfunction

  function automatic void mdl_reset();
    m_pc = 0; m_modeq = 0; m_cnt = 0; m_rot = 0;
    m_bq = 0; m_bph = 0; m_pwm = 0;
    exp_led = 8'h00; exp_tick = 1'b0;
  endfunction

  function automatic void mdl_edge(input logic p, input logic s,
                                   input logic [1:0] m,
                                   input logic [1:0] sp);
    int lim;
    int pos;
    bit a;
    lim = 16 >> sp;
    a = p ? s : (m_pc >= lim - 1);
    if (!p) m_pc = a ? 0 : m_pc + 1;
    if (a) begin
      if (int'(m) != m_modeq) begin
        m_modeq = int'(m);
        m_cnt = 0; m_rot = 0; m_bq = 0; m_bph = 0;
      end else begin
        m_cnt = (m_cnt + 1) % 256;
        m_rot = (m_rot + 1) % 8;
        m_bq  = (m_bq + 1) % 14;
        m_bph = (m_bph + 1) % 30;
      end
    end
    exp_tick = a;
    pos = (m_bq <= 7) ? m_bq : 14 - m_bq;
    case (m_modeq)
      0: exp_led = 8'(m_cnt);
      1: exp_led = 8'(1 << m_rot);
      2: exp_led = 8'(1 << pos);
      default: exp_led = (m_pwm < bph_duty(m_bph)) ? 8'hFF : 8'h00;
    endcase
    m_pwm = (m_pwm + 1) % 16;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input logic p, input logic s,
                     input logic [1:0] m, input logic [1:0] sp);
    pause = p; step = s; mode = m; speed = sp;
    @(posedge clk);
    mdl_edge(p, s, m, sp);
    #1;
    chk("led_model", led, exp_led);
    chk("tick_model", tick, exp_tick);
  endtask

  task automatic wait_tick(input logic [1:0] m, input logic [1:0] sp);
    int n;
    n = 0;
    do begin
      cyc(1'b0, 1'b0, m, sp);
      n++;
    end while (tick !== 1'b1 && n < 64);
    chk("tick_timeout", tick, 1);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    mdl_reset();
    chk("rst_led", led, 0);
    chk("rst_tick", tick, 0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  logic [7:0] shq [9] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
                          8'h20, 8'h40, 8'h80, 8'h01};
  logic [7:0] bq [16] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20,
                          8'h40, 8'h80, 8'h40, 8'h20, 8'h10, 8'h08,
                          8'h04, 8'h02, 8'h01, 8'h02};
  logic [7:0] v;
  int on;
  logic rp;
  logic [1:0] rm, rs;

  initial begin
    // count from reset, limit 8
    do_reset();
    for (int i = 1; i <= 24; i++) begin
      cyc(1'b0, 1'b0, 2'd0, 2'd1);
      if (i % 8 == 0) begin
        chk("cnt_tick", tick, 1);
        chk("cnt_led", led, i / 8);
      end
    end
    for (int i = 0; i < 255 * 8 - 24; i++) cyc(1'b0, 1'b0, 2'd0, 2'd1);
    chk("cnt_ff", led, 8'hFF);
    for (int i = 0; i < 8; i++) cyc(1'b0, 1'b0, 2'd0, 2'd1);
    chk("cnt_wrap", led, 8'h00);
    chk("cnt_wrap_tick", tick, 1);

    // rotate
    for (int i = 0; i < 9; i++) begin
      wait_tick(2'd1, 2'd1);
      chk("shift_led", led, shq[i]);
    end

    // bounce
    for (int i = 0; i < 16; i++) begin
      wait_tick(2'd2, 2'd1);
      chk("bounce_led", led, bq[i]);
    end

    // speed-up mid count: limit 16, pcnt=5, then limit 4
    wait_tick(2'd0, 2'd0);
    chk("spd_load", led, 0);
    for (int i = 0; i < 5; i++) cyc(1'b0, 1'b0, 2'd0, 2'd0);
    cyc(1'b0, 1'b0, 2'd0, 2'd2);
    chk("spd_fast_tick", tick, 1);
    cyc(1'b0, 1'b0, 2'd0, 2'd2);
    chk("spd_t1", tick, 0);
    cyc(1'b0, 1'b0, 2'd0, 2'd2);
    chk("spd_t2", tick, 0);
    cyc(1'b0, 1'b0, 2'd0, 2'd2);
    chk("spd_t3", tick, 0);
    cyc(1'b0, 1'b0, 2'd0, 2'd2);
    chk("spd_t4", tick, 1);

    // pause mid count at pcnt=2
    cyc(1'b0, 1'b0, 2'd0, 2'd2);
    cyc(1'b0, 1'b0, 2'd0, 2'd2);
    v = led;
    for (int i = 0; i < 50; i++) begin
      cyc(1'b1, 1'b0, 2'd0, 2'd2);
      chk("pause_tick", tick, 0);
      chk("pause_led", led, v);
    end
    cyc(1'b0, 1'b0, 2'd0, 2'd2);
    chk("resume_t1", tick, 0);
    cyc(1'b0, 1'b0, 2'd0, 2'd2);
    chk("resume_t2", tick, 1);
    chk("resume_led", led, 8'(v + 8'd1));

    // single step while paused
    do_reset();
    for (int k = 1; k <= 3; k++) begin
      cyc(1'b1, 1'b1, 2'd0, 2'd0);
      chk("step_tick", tick, 1);
      chk("step_led", led, k);
      cyc(1'b1, 1'b0, 2'd0, 2'd0);
      chk("step_tick_low", tick, 0);
    end
    cyc(1'b0, 1'b1, 2'd0, 2'd0);
    chk("step_unpaused_tick", tick, 0);
    chk("step_unpaused_led", led, 3);

    // breathe: duty k gives k on-cycles per 16
    wait_tick(2'd3, 2'd0);
    for (int k = 0; k < 32; k++) begin
      on = 0;
      for (int j = 0; j < 16; j++) begin
        if (j > 0) cyc(1'b0, 1'b0, 2'd3, 2'd0);
        chk("breathe_lvl", 32'(led == 8'h00 || led == 8'hFF), 1);
        if (led == 8'hFF) on++;
      end
      chk("breathe_on", on, bph_duty(k % 30));
      cyc(1'b0, 1'b0, 2'd3, 2'd0);
      chk("breathe_tick", tick, 1);
    end

    // async reset mid-bounce at 0x20 heading down
    do_reset();
    for (int i = 0; i < 10; i++) wait_tick(2'd2, 2'd1);
    chk("bounce_pre", led, 8'h20);
    rst_n = 1'b0;
    #1;
    chk("async_led", led, 0);
    chk("async_tick", tick, 0);
    mdl_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) cyc(1'b0, 1'b0, 2'd2, 2'd1);
    chk("post_rst_tick", tick, 1);
    chk("post_rst_led", led, 8'h01);

    // random
    rp = 1'b0; rm = 2'd2; rs = 2'd1;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(15) == 0) rp = ~rp;
      if ($urandom_range(63) == 0) rm = 2'($urandom_range(3));
      if ($urandom_range(63) == 0) rs = 2'($urandom_range(3));
      cyc(rp, 1'($urandom_range(3) == 0), rm, rs);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
